// File: rtl/ads1675_emu_tx.sv
// ============================================================================
// ads1675_emu_tx : ADS1675 serial-output emulator (AXI-Stream in, SCLK/DRDY/DOUT out)
// Revision 1.0
// ============================================================================
`default_nettype none

module ads1675_emu_tx #(
    parameter int DR     = 5,
    parameter int DRDY_W = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        ctrl_start,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        tx_sclk,
    output logic        tx_drdy,
    output logic        tx_dout,
    output logic        busy,
    output logic        underrun
);

    localparam int FRAME_LEN = 24 << (5 - DR);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(DRDY_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [23:0]        shreg_q, shreg_d;
    logic [CNT_W-1:0]   drdy_cnt_q, drdy_cnt_d;
    logic               first_q, first_d;
    logic               sclk_q, sclk_d;
    logic               drdy_q, drdy_d;
    logic               dout_q, dout_d;
    logic               tready_q, tready_d;
    logic               underrun_q, underrun_d;
    logic               load;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        drdy_cnt_d = drdy_cnt_q;
        first_d    = first_q;
        sclk_d     = ~sclk_q;
        drdy_d     = drdy_q;
        dout_d     = dout_q;
        tready_d   = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        // All framing outputs move only on the SCLK falling edge (tick)
        if (sclk_q) begin
            if (drdy_q) begin
                if (drdy_cnt_q == DRDY_LAST) begin
                    drdy_d = 1'b0;
                end else begin
                    drdy_cnt_d = drdy_cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    dout_d    = 1'b0;
                    drdy_d    = 1'b0;
                    bit_idx_d = '0;
                    if (ctrl_start) begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (ctrl_start) begin
                            load = 1'b1;
                        end else begin
                            state_d    = FLUSH;
                            bit_idx_d  = '0;
                            shreg_d    = '0;
                            dout_d     = 1'b0;
                            drdy_d     = 1'b1;
                            drdy_cnt_d = CNT_W'(1);
                        end
                    end else begin
                        // Zeros shift in, so indices beyond 23 pad DOUT low
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        dout_d    = shreg_q[22];
                        shreg_d   = {shreg_q[22:0], 1'b0};
                    end
                end
                FLUSH: begin
                    dout_d = 1'b0;
                    if (drdy_cnt_q == DRDY_LAST) begin
                        state_d = IDLE;
                        first_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                bit_idx_d = '0;
                tready_d  = 1'b1;
                first_d   = 1'b0;
                if (s_axis_tvalid) begin
                    shreg_d = s_axis_tdata;
                    dout_d  = s_axis_tdata[23];
                end else begin
                    shreg_d    = '0;
                    dout_d     = 1'b0;
                    underrun_d = 1'b1;
                end
                // The first frame of a run has no predecessor to close
                if (!first_q) begin
                    drdy_d     = 1'b1;
                    drdy_cnt_d = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            drdy_cnt_q <= '0;
            first_q    <= 1'b1;
            sclk_q     <= 1'b0;
            drdy_q     <= 1'b0;
            dout_q     <= 1'b0;
            tready_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            drdy_cnt_q <= drdy_cnt_d;
            first_q    <= first_d;
            sclk_q     <= sclk_d;
            drdy_q     <= drdy_d;
            dout_q     <= dout_d;
            tready_q   <= tready_d;
            underrun_q <= underrun_d;
        end
    end

    assign tx_sclk       = sclk_q;
    assign tx_drdy       = drdy_q;
    assign tx_dout       = dout_q;
    assign s_axis_tready = tready_q;
    assign underrun      = underrun_q;
    assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ads1675_emu_tx.sv
// ============================================================================
// tb_ads1675_emu_tx : directed bench for ads1675_emu_tx (DR=5 and DR=3 instances)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ads1675_emu_tx;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0, start3 = 1'b0;
    logic [23:0] tdata = 24'h0, tdata3 = 24'h0;
    logic        tvalid = 1'b0, tvalid3 = 1'b0;
    logic        tready, sclk, drdy, dout, busy, urun;
    logic        tready3, sclk3, drdy3, dout3, busy3, urun3;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    ads1675_emu_tx #(.DR(5), .DRDY_W(4)) dut (
        .aclk(aclk), .areset(areset), .ctrl_start(start),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .tx_sclk(sclk), .tx_drdy(drdy), .tx_dout(dout), .busy(busy), .underrun(urun)
    );

    ads1675_emu_tx #(.DR(3), .DRDY_W(4)) dut3 (
        .aclk(aclk), .areset(areset), .ctrl_start(start3),
        .s_axis_tdata(tdata3), .s_axis_tvalid(tvalid3), .s_axis_tready(tready3),
        .tx_sclk(sclk3), .tx_drdy(drdy3), .tx_dout(dout3), .busy(busy3), .underrun(urun3)
    );

    task automatic tick();
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if ({sclk, drdy, dout, tready, urun, busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_outputs got %b want 000000", {sclk, drdy, dout, tready, urun, busy});
        end
        n_vec++; if ({sclk3, drdy3, dout3, tready3, urun3, busy3} !== 6'b0) begin
            n_err++; $display("FAIL reset_outputs3 got %b want 000000", {sclk3, drdy3, dout3, tready3, urun3, busy3});
        end
    endtask

    // Frames 1 and 2 at DR=5: 0x800001 then 0x7FFFFE
    task automatic test_basic();
        logic [23:0] d1, d2;
        logic        bad;
        d1 = 24'h800001; d2 = 24'h7FFFFE;
        start = 1'b1; tvalid = 1'b1; tdata = d1;
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk);
        n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL sclk_after_release got %b want 1", sclk); end
        for (int k = 0; k < 10 && tready !== 1'b1; k++) @(negedge aclk);
        n_vec++; if ({tready, dout, drdy, busy} !== 4'b1101) begin
            n_err++; $display("FAIL load1 {tready,dout,drdy,busy} got %b want 1101", {tready, dout, drdy, busy});
        end
        tdata = d2;
        @(negedge aclk);
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL tready_width got %b want 0", tready); end
        @(negedge aclk);
        bad = 1'b0;
        for (int i = 1; i < 24; i++) begin
            if (i > 1) tick();
            if (dout !== d1[23-i] || tready !== 1'b0 || drdy !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL frame1_bits got mismatch want 800001 msb-first no tready/drdy"); end
        tick();
        n_vec++; if ({tready, dout, drdy} !== 3'b101) begin
            n_err++; $display("FAIL load2 {tready,dout,drdy} got %b want 101", {tready, dout, drdy});
        end
        tvalid = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < 24; i++) begin
            tick();
            if (dout !== d2[23-i]) bad = 1'b1;
            if (drdy !== (i < 4)) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL frame2_bits_drdy got mismatch want 7FFFFE, drdy 4 sclk"); end
    endtask

    task automatic test_underrun();
        logic bad;
        tick();
        n_vec++; if ({tready, urun, dout, drdy} !== 4'b1101) begin
            n_err++; $display("FAIL underrun_load {tready,urun,dout,drdy} got %b want 1101", {tready, urun, dout, drdy});
        end
        tvalid = 1'b1; tdata = 24'h123456;
        @(negedge aclk);
        n_vec++; if ({tready, urun} !== 2'b00) begin
            n_err++; $display("FAIL underrun_width got %b want 00", {tready, urun});
        end
        @(negedge aclk);
        bad = 1'b0;
        for (int i = 1; i < 24; i++) begin
            if (i > 1) tick();
            if (dout !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL underrun_zero_bits got 1 want 0"); end
    endtask

    task automatic test_stop();
        logic [23:0] d;
        logic        bad;
        d = 24'h123456;
        tick();
        n_vec++; if ({tready, urun, dout, drdy} !== 4'b1001) begin
            n_err++; $display("FAIL load4 {tready,urun,dout,drdy} got %b want 1001", {tready, urun, dout, drdy});
        end
        bad = 1'b0;
        for (int i = 1; i < 24; i++) begin
            tick();
            if (dout !== d[23-i]) bad = 1'b1;
            if (i == 10) start = 1'b0;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL stop_frame_bits got mismatch want 123456 complete"); end
        tick();
        n_vec++; if ({tready, dout, drdy, busy} !== 4'b0011) begin
            n_err++; $display("FAIL flush_entry {tready,dout,drdy,busy} got %b want 0011", {tready, dout, drdy, busy});
        end
        bad = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            if ({drdy, busy} !== 2'b11) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL flush_hold got drdy/busy low want high 4 sclk"); end
        tick();
        n_vec++; if ({drdy, busy, dout} !== 3'b000) begin
            n_err++; $display("FAIL flush_exit {drdy,busy,dout} got %b want 000", {drdy, busy, dout});
        end
        repeat (4) tick();
        n_vec++; if ({drdy, busy, dout, tready} !== 4'b0000) begin
            n_err++; $display("FAIL idle_stays got %b want 0000", {drdy, busy, dout, tready});
        end
    endtask

    task automatic test_async_reset();
        tdata = 24'hFFFFFF; tvalid = 1'b1; start = 1'b1;
        for (int k = 0; k < 10 && tready !== 1'b1; k++) @(negedge aclk);
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL restart_tready got %b want 1", tready); end
        repeat (12) tick();
        n_vec++; if ({dout, busy} !== 2'b11) begin
            n_err++; $display("FAIL pre_reset {dout,busy} got %b want 11", {dout, busy});
        end
        areset = 1'b1; start = 1'b0;
        #1;
        n_vec++; if ({dout, drdy, tready, busy, sclk} !== 5'b0) begin
            n_err++; $display("FAIL async_reset got %b want 00000", {dout, drdy, tready, busy, sclk});
        end
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk);
        n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL sclk_resume got %b want 1", sclk); end
        @(negedge aclk);
        n_vec++; if ({sclk, busy, dout, drdy} !== 4'b0000) begin
            n_err++; $display("FAIL idle_after_reset got %b want 0000", {sclk, busy, dout, drdy});
        end
    endtask

    // DR=3: FRAME_LEN=96, 24 data bits then 72 zero bits, DRDY period 192 aclk
    task automatic test_dr3();
        logic [23:0] d;
        logic        bad;
        time         t0;
        d = 24'h5A5A5A;
        start3 = 1'b1; tvalid3 = 1'b1; tdata3 = d;
        for (int k = 0; k < 10 && tready3 !== 1'b1; k++) @(negedge aclk);
        t0 = $time;
        n_vec++; if ({tready3, dout3, drdy3} !== 3'b100) begin
            n_err++; $display("FAIL dr3_load {tready,dout,drdy} got %b want 100", {tready3, dout3, drdy3});
        end
        tdata3 = 24'h000000;
        bad = 1'b0;
        for (int i = 1; i < 96; i++) begin
            tick();
            if (dout3 !== ((i < 24) ? d[23-i] : 1'b0) || drdy3 !== 1'b0 || tready3 !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad) begin n_err++; $display("FAIL dr3_frame got mismatch want 5A5A5A then 72 zeros"); end
        tick();
        n_vec++; if ({tready3, drdy3} !== 2'b11 || ($time - t0) != 1920) begin
            n_err++; $display("FAIL dr3_period {tready,drdy} got %b after %0t want 11 after 1920", {tready3, drdy3}, $time - t0);
        end
        start3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_stop();
        test_async_reset();
        test_dr3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
